// File: rtl/lfsr_rng_multi.sv
// Multi-channel bounded random number generator on a Fibonacci LFSR, negedge-clocked.
// Optional SEED_LOAD_EN macro adds seed_load/seed_in ports for reseeding while idle.
module lfsr_rng_multi #(
  parameter int unsigned          LFSR_W    = 24,
  parameter logic [LFSR_W-1:0]    TAP_MASK  = 24'hE10000,
  parameter logic [LFSR_W-1:0]    SEED      = 24'h0ACE1E,
  parameter int unsigned          NUM_CH    = 3,
  parameter int unsigned          OUT_W     = 4,
  parameter int unsigned          MAX_VAL   = 9,
  parameter int unsigned          MAX_RETRY = 15
) (
  input  logic                      clka,
  input  logic                      restart,
  input  logic                      new_game,
  input  logic                      req,
`ifdef SEED_LOAD_EN
  input  logic                      seed_load,
  input  logic [LFSR_W-1:0]         seed_in,
`endif
  output logic                      busy,
  output logic                      valid,
  output logic [NUM_CH*OUT_W-1:0]   rand_out,
  output logic                      fallback,
  output logic [LFSR_W-1:0]         lfsr_q
);

  localparam int unsigned CNT_W = $clog2(MAX_RETRY + 1);
  localparam int unsigned RW    = NUM_CH * OUT_W;

  typedef enum logic [1:0] {StIdle, StStep, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [LFSR_W-1:0] r_lfsr, w_lfsr_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [NUM_CH-1:0] r_acc, w_acc_d;
  logic [RW-1:0]     r_work, w_work_d;
  logic [RW-1:0]     r_rand, w_rand_d;
  logic              r_fb_work, w_fb_work_d;
  logic              r_fb, w_fb_d;

  logic              w_seed_load;
  logic [LFSR_W-1:0] w_seed_in;
  logic [LFSR_W-1:0] w_shift;
  logic [LFSR_W-1:0] w_adv;
  logic [OUT_W-1:0]  w_cand;

`ifdef SEED_LOAD_EN
  assign w_seed_load = seed_load;
  assign w_seed_in   = seed_in;
`else
  assign w_seed_load = 1'b0;
  assign w_seed_in   = '0;
`endif

  assign w_shift = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAP_MASK)};
  // Lock-up guard: an all-zero register would otherwise shift zeros forever.
  assign w_adv   = (r_lfsr == '0) ? SEED : w_shift;

  always_comb begin
    w_state_d   = r_state;
    w_lfsr_d    = (r_lfsr == '0) ? SEED : r_lfsr;
    w_cnt_d     = r_cnt;
    w_acc_d     = r_acc;
    w_work_d    = r_work;
    w_rand_d    = r_rand;
    w_fb_work_d = r_fb_work;
    w_fb_d      = r_fb;
    w_cand      = '0;

    if (new_game) begin
      w_state_d   = StIdle;
      w_rand_d    = '0;
      w_fb_d      = 1'b0;
      w_fb_work_d = 1'b0;
      w_acc_d     = '0;
      w_cnt_d     = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_seed_load) begin
            w_lfsr_d = (w_seed_in == '0) ? SEED : w_seed_in;
          end else if (req) begin
            w_state_d   = StStep;
            w_acc_d     = '0;
            w_cnt_d     = '0;
            w_fb_work_d = 1'b0;
          end
        end
        StStep: begin
          w_lfsr_d = w_adv;
          w_cnt_d  = r_cnt + 1'b1;
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_cand = w_adv[c*OUT_W +: OUT_W];
            if (!r_acc[c] && (w_cand != '0) && (w_cand <= OUT_W'(MAX_VAL))) begin
              w_work_d[c*OUT_W +: OUT_W] = w_cand;
              w_acc_d[c]                 = 1'b1;
            end
          end
          if (&w_acc_d) begin
            w_state_d = StDone;
            w_rand_d  = w_work_d;
            w_fb_d    = r_fb_work;
          end else if (w_cnt_d == CNT_W'(MAX_RETRY)) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              if (!w_acc_d[c]) begin
                w_work_d[c*OUT_W +: OUT_W] = OUT_W'((c % MAX_VAL) + 1);
              end
            end
            w_fb_work_d = 1'b1;
            w_state_d   = StDone;
            w_rand_d    = w_work_d;
            w_fb_d      = 1'b1;
          end
        end
        StDone: begin
          w_state_d = StIdle;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(negedge clka) begin
    if (restart) begin
      r_state   <= StIdle;
      r_lfsr    <= SEED;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_work    <= '0;
      r_rand    <= '0;
      r_fb_work <= 1'b0;
      r_fb      <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_lfsr    <= w_lfsr_d;
      r_cnt     <= w_cnt_d;
      r_acc     <= w_acc_d;
      r_work    <= w_work_d;
      r_rand    <= w_rand_d;
      r_fb_work <= w_fb_work_d;
      r_fb      <= w_fb_d;
    end
  end

  assign busy     = (r_state != StIdle);
  assign valid    = (r_state == StDone);
  assign rand_out = r_rand;
  assign fallback = r_fb;
  assign lfsr_q   = r_lfsr;

endmodule

// File: tb/tb_lfsr_rng_multi.sv
// Self-checking bench for lfsr_rng_multi: transaction-level model plus directed literal checks.
// Seed-load stimulus is included only when SEED_LOAD_EN is defined.
module tb_lfsr_rng_multi;

  localparam int unsigned LW     = 24;
  localparam logic [23:0] TAP    = 24'hE10000;
  localparam logic [23:0] SEEDV  = 24'h0ACE1E;
  localparam int unsigned NCH    = 3;
  localparam int unsigned OW     = 4;
  localparam int unsigned MAXV   = 9;
  localparam int unsigned MAXR   = 15;

  logic        clka = 1'b0;
  logic        restart, new_game, req, seed_load;
  logic [23:0] seed_in;
  logic        busy, valid, fallback;
  logic [11:0] rand_out;
  logic [23:0] lfsr_q;

  logic        restart1, req1, zero1, seed_load1;
  logic [23:0] seed_in1;
  logic        busy1, valid1, fallback1;
  logic [11:0] rand_out1;
  logic [23:0] lfsr_q1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clka = ~clka;

  lfsr_rng_multi u_dut (
    .clka     (clka),
    .restart  (restart),
    .new_game (new_game),
    .req      (req),
`ifdef SEED_LOAD_EN
    .seed_load(seed_load),
    .seed_in  (seed_in),
`endif
    .busy     (busy),
    .valid    (valid),
    .rand_out (rand_out),
    .fallback (fallback),
    .lfsr_q   (lfsr_q)
  );

  lfsr_rng_multi #(.MAX_RETRY(1)) u_dut1 (
    .clka     (clka),
    .restart  (restart1),
    .new_game (zero1),
    .req      (req1),
`ifdef SEED_LOAD_EN
    .seed_load(seed_load1),
    .seed_in  (seed_in1),
`endif
    .busy     (busy1),
    .valid    (valid1),
    .rand_out (rand_out1),
    .fallback (fallback1),
    .lfsr_q   (lfsr_q1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [23:0] nxt(input logic [23:0] x);
    if (x == 24'h0) return SEEDV;
    return {x[22:0], ^(x & TAP)};
  endfunction

  logic [23:0] m_seq[$];
  logic [23:0] m_lfsr;
  logic [11:0] m_rand, p_res;
  logic        m_fb, p_fb, m_done, m_init;
  int          m_left;

  // Plan a whole request: every LFSR value it will visit and the final result.
  task automatic plan(input logic [23:0] start);
    logic [23:0] x;
    int          vals[NCH];
    bit          acc[NCH];
    int          k, nacc, v;
    x = start; k = 0; nacc = 0;
    m_seq.delete();
    for (int c = 0; c < NCH; c++) begin acc[c] = 0; vals[c] = 0; end
    while (nacc < NCH && k < MAXR) begin
      x = nxt(x);
      k++;
      m_seq.push_back(x);
      for (int c = 0; c < NCH; c++) begin
        v = int'((x >> (c * OW)) & 24'hF);
        if (!acc[c] && v >= 1 && v <= MAXV) begin
          acc[c] = 1; vals[c] = v; nacc++;
        end
      end
    end
    p_fb = 0;
    for (int c = 0; c < NCH; c++) begin
      if (!acc[c]) begin vals[c] = (c % MAXV) + 1; p_fb = 1; end
    end
    p_res = 12'(vals[0] + vals[1] * 16 + vals[2] * 256);
  endtask

  initial begin m_init = 0; m_done = 0; m_left = 0; end

  always @(negedge clka) begin
    if (restart) begin
      m_init = 1; m_lfsr = SEEDV; m_left = 0; m_done = 0;
      m_rand = '0; m_fb = 0; m_seq.delete();
    end else if (m_init) begin
      if (new_game) begin
        m_left = 0; m_done = 0; m_rand = '0; m_fb = 0; m_seq.delete();
      end else if (m_done) begin
        m_done = 0;
      end else if (m_left > 0) begin
        m_lfsr = m_seq.pop_front();
        m_left--;
        if (m_left == 0) begin m_done = 1; m_rand = p_res; m_fb = p_fb; end
`ifdef SEED_LOAD_EN
      end else if (seed_load) begin
        m_lfsr = (seed_in == 24'h0) ? SEEDV : seed_in;
`endif
      end else if (req) begin
        plan(m_lfsr);
        m_left = m_seq.size();
      end
    end
  end

  always @(posedge clka) begin
    if (m_init) begin
      chk("busy",     64'(busy),     64'(m_left > 0 || m_done));
      chk("valid",    64'(valid),    64'(m_done));
      chk("rand_out", 64'(rand_out), 64'(m_rand));
      chk("fallback", 64'(fallback), 64'(m_fb));
      chk("lfsr_q",   64'(lfsr_q),   64'(m_lfsr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step_cyc();
    @(negedge clka);
    @(posedge clka);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && !valid; i++) step_cyc();
    chk("wait_valid", 64'(valid), 64'd1);
  endtask

  initial begin
    int last_v, pulses;
    restart = 1; new_game = 0; req = 0; seed_load = 0; seed_in = '0;
    restart1 = 1; req1 = 0; zero1 = 0; seed_load1 = 0; seed_in1 = '0;

    chk("model_step1", 64'(nxt(24'h0ACE1E)), 64'h159C3C);
    chk("model_step2", 64'(nxt(24'h159C3C)), 64'h2B3879);

    step_cyc();
    chk("rst_lfsr", 64'(lfsr_q), 64'h0ACE1E);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rand", 64'(rand_out), 64'd0);

    // Basic request on both instances.
    restart = 0; restart1 = 0; req = 1; req1 = 1;
    step_cyc();
    req = 0; req1 = 0;
    chk("step_busy", 64'(busy), 64'd1);
    step_cyc();
    chk("step1_lfsr", 64'(lfsr_q), 64'h159C3C);
    chk("r1_valid", 64'(valid1), 64'd1);
    chk("r1_rand", 64'(rand_out1), 64'h331);
    chk("r1_fb", 64'(fallback1), 64'd1);
    chk("r1_lfsr", 64'(lfsr_q1), 64'h159C3C);
    step_cyc();
    chk("step2_lfsr", 64'(lfsr_q), 64'h2B3879);
    chk("done_valid", 64'(valid), 64'd1);
    chk("done_rand", 64'(rand_out), 64'h839);
    chk("done_fb", 64'(fallback), 64'd0);
    step_cyc();
    chk("idle_valid", 64'(valid), 64'd0);
    chk("hold_rand", 64'(rand_out), 64'h839);

    // Abort mid-request with new_game.
    req = 1;
    step_cyc();
    req = 0;
    step_cyc();
    new_game = 1;
    step_cyc();
    new_game = 0;
    chk("ng_valid", 64'(valid), 64'd0);
    chk("ng_rand", 64'(rand_out), 64'd0);
    chk("ng_lfsr", 64'(lfsr_q), 64'h5670F2);
    req = 1;
    step_cyc();
    req = 0;
    wait_valid();
    step_cyc();

    // Restart while in DONE.
    req = 1;
    step_cyc();
    req = 0;
    wait_valid();
    restart = 1;
    step_cyc();
    restart = 0;
    chk("rd_valid", 64'(valid), 64'd0);
    chk("rd_busy", 64'(busy), 64'd0);
    chk("rd_rand", 64'(rand_out), 64'd0);
    chk("rd_lfsr", 64'(lfsr_q), 64'h0ACE1E);

`ifdef SEED_LOAD_EN
    req = 1;
    step_cyc();
    req = 0;
    wait_valid();
    step_cyc();
    seed_load = 1; seed_in = '0;
    step_cyc();
    chk("seed_zero", 64'(lfsr_q), 64'h0ACE1E);
    seed_in = 24'h123456;
    step_cyc();
    chk("seed_val", 64'(lfsr_q), 64'h123456);
    seed_load = 0;
`endif

    // req held high: pulses must be at least three cycles apart.
    req = 1; last_v = -100; pulses = 0;
    for (int i = 0; i < 60; i++) begin
      step_cyc();
      if (valid) begin
        if (pulses > 0) chk("valid_gap", 64'(i - last_v >= 3), 64'd1);
        last_v = i; pulses++;
      end
    end
    chk("held_pulses", 64'(pulses >= 3), 64'd1);
    req = 0;
    step_cyc();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      req       = ($urandom_range(0, 1) == 1);
      new_game  = ($urandom_range(0, 99) < 3);
      restart   = ($urandom_range(0, 199) == 0);
      seed_load = ($urandom_range(0, 19) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
      step_cyc();
    end
    restart = 0; new_game = 0; req = 0; seed_load = 0;
    step_cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_multi.md
LFSR_RNG_MULTI -- requirements
Module: lfsr_rng_multi

Interface
REQ-001 Parameter LFSR_W, 24, LFSR state width.
REQ-002 Parameter TAP_MASK, 24'hE10000, Fibonacci feedback taps; bit i set means lfsr[i] feeds the XOR.
REQ-003 Parameter SEED, 24'h0ACE1E, reset/lock-up seed; SHALL be nonzero.
REQ-004 Parameter NUM_CH, 3, number of output channels.
REQ-005 Parameter OUT_W, 4, bits per channel; NUM_CH*OUT_W SHALL be <= LFSR_W.
REQ-006 Parameter MAX_VAL, 9, accepted range is 1..MAX_VAL; MAX_VAL SHALL be < 2^OUT_W.
REQ-007 Parameter MAX_RETRY, 15, maximum STEP cycles per request; SHALL be >= 1.
REQ-008 clka  in  1  sole clock; all state updates on the negedge.
REQ-009 restart  in  1  synchronous active-high reset.
REQ-010 new_game  in  1  synchronous abort and clear of outputs; LFSR is kept.
REQ-011 req  in  1  request one set of NUM_CH values; sampled only in IDLE.
REQ-012 busy  out  1  high in STEP and DONE.
REQ-013 valid  out  1  one-cycle pulse; rand_out is new.
REQ-014 rand_out  out  NUM_CH*OUT_W  channel c occupies [(c+1)*OUT_W-1 : c*OUT_W].
REQ-015 fallback  out  1  high if any channel of the last result used its fallback value.
REQ-016 lfsr_q  out  LFSR_W  current LFSR state (observability).

Function
REQ-017 LFSR step SHALL be: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAP_MASK)}.
REQ-018 The LFSR SHALL advance only in STEP and SHALL hold in all other states.
REQ-019 FSM states SHALL be IDLE, STEP, DONE.
- IDLE->STEP on req=1.
- STEP->STEP while channels remain unaccepted and retry count < MAX_RETRY.
- STEP->DONE when all channels are accepted or the count reaches MAX_RETRY.
- DONE->IDLE unconditionally.
REQ-020 On IDLE->STEP the block SHALL clear all accept flags, clear fallback and zero the retry counter; rand_out holds its previous value until DONE.
REQ-021 Each STEP cycle evaluates every unaccepted channel c.
- Candidate is the OUT_W slice c of the post-shift LFSR value.
- If the candidate is in 1..MAX_VAL, it is captured into channel c and c is marked accepted.
- Accepted channels SHALL NOT change again within the request.
REQ-022 The retry counter SHALL increment once per STEP cycle.
REQ-023 When the counter reaches MAX_RETRY with channels still unaccepted, each such channel SHALL take (c mod MAX_VAL)+1 and fallback SHALL be set.
REQ-024 valid SHALL be 1 exactly while in DONE.
REQ-025 Minimum latency: req sampled at edge N gives STEP at N+1 and DONE after edge N+1, so valid is high for the cycle following edge N+1.
REQ-026 rand_out and fallback SHALL hold stable from DONE until the next DONE, new_game or restart.
REQ-027 req while busy SHALL be ignored (no queuing).
REQ-028 new_game, in any state, SHALL force IDLE, rand_out=0, valid=0 and fallback=0; the LFSR is unchanged and an in-flight request is dropped.
REQ-029 Priority SHALL be restart > new_game > seed_load > req.
REQ-030 If the LFSR is ever all-zero at a clock edge, the next value SHALL be SEED (lock-up guard).

Reset
REQ-031 restart=1 SHALL set: lfsr=SEED, state IDLE, rand_out=0, valid=0, busy=0, fallback=0, retry counter 0, accept flags 0.
REQ-032 Mid-operation restart SHALL abort the request with no valid pulse.

Configuration
REQ-033 With SEED_LOAD_EN defined, ports seed_load (in, 1) and seed_in (in, LFSR_W) SHALL exist.
- In IDLE, seed_load=1 SHALL set lfsr=seed_in, or SEED if seed_in=0.
- seed_load SHALL be ignored in STEP and DONE.
- A simultaneous req SHALL be ignored that cycle.
REQ-034 Without SEED_LOAD_EN, those ports SHALL be absent and the LFSR is seeded only from SEED.

Verification
REQ-035 Default params, restart then req -> STEP1 lfsr=24'h159C3C (ch1=3 accepted); STEP2 lfsr=24'h2B3879; valid pulse with rand_out=12'h839, fallback=0.
REQ-036 MAX_RETRY=1, restart then req -> one STEP; rand_out=12'h331, fallback=1, lfsr=24'h159C3C.
REQ-037 restart then req, with new_game asserted in the STEP cycle -> no valid; rand_out=0; lfsr retains its advanced value; next req completes normally.
REQ-038 req held high continuously -> one valid per 3+ cycles; req during busy is not counted; busy is low only in IDLE.
REQ-039 SEED_LOAD_EN: seed_load with seed_in=0 in IDLE -> lfsr_q=24'h0ACE1E; seed_load during STEP -> lfsr unchanged by the load.
REQ-040 restart asserted in DONE -> valid deasserts next cycle; all outputs 0; lfsr_q=24'h0ACE1E.
